sub_bytes_iter: RTL

SUB_BYTES_ITER -- requirements
Module: sub_bytes_iter

---
 rtl/sub_bytes_iter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sub_bytes_iter.sv
// rtl/sub_bytes_iter.sv - iterative AES SubBytes / InvSubBytes over an NB-column state
module aes_sbox #(
    parameter bit INVERSE = 1'b0
) (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Row-major 16x16 tables, entry 0x00 in the most significant byte.
    localparam logic [2047:0] FWD_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [2047:0] INV_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    assign y = INVERSE ? INV_TABLE[{~a, 3'b000} +: 8] : FWD_TABLE[{~a, 3'b000} +: 8];
endmodule

module sub_bytes_iter #(
    parameter int NB    = 4,
    parameter int LANES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NB-1:0]  in_data,
    input  logic              inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic              busy
);
    localparam int STEPS = 4*NB/LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS-1);

    generate
        if (!(NB == 4 || NB == 6 || NB == 8) ||
            !(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16) ||
            ((4*NB) % LANES) != 0) begin : g_bad_params
            $error("sub_bytes_iter: illegal NB/LANES combination");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_nx;
    logic [32*NB-1:0]  data_q, data_upd;
    logic [CW-1:0]     step_q;
    logic              inv_q;
    logic [7:0]        lane_in  [LANES];
    logic [7:0]        fwd_out  [LANES];
    logic [7:0]        inv_out  [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_sbox #(.INVERSE(1'b0)) u_fwd (.a(lane_in[l]), .y(fwd_out[l]));
        aes_sbox #(.INVERSE(1'b1)) u_inv (.a(lane_in[l]), .y(inv_out[l]));
    end

    // Step s owns flat bytes s*LANES .. s*LANES+LANES-1; constant slices keep the muxes static.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = '0;
        end
        data_upd = data_q;
        for (int s = 0; s < STEPS; s++) begin
            if (step_q == CW'(s)) begin
                for (int l = 0; l < LANES; l++) begin
                    lane_in[l] = data_q[8*(s*LANES+l) +: 8];
                    data_upd[8*(s*LANES+l) +: 8] = inv_q ? inv_out[l] : fwd_out[l];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)             state_nx = S_BUSY;
            S_BUSY:  if (step_q == LAST_STEP)  state_nx = S_DONE;
            S_DONE:  if (out_ready)            state_nx = S_IDLE;
            default:                           state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q == S_BUSY);
        out_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            step_q <= '0;
            inv_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        inv_q  <= inv;
                        step_q <= '0;
                    end
                end
                S_BUSY: begin
                    data_q <= data_upd;
                    step_q <= (step_q == LAST_STEP) ? '0 : step_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_data = data_q;
endmodule
